svreal_mac_pipe_mod: RTL and testbench

- Pipelined fixed-point multiply-accumulate operating on svreal numbers (signed significand plus signed exponent).
- Accepts a stream of (a, b) operand beats over a valid/ready handshake and multiplies them exactly.
- Aligns each product to the output format with saturation.
- Either accumulates products into packet sums delimited by a last flag, or passes each product through, selected per beat.
- Serves as the datapath core for FIR/integrator blocks built on the svreal library.

---
 rtl/svreal_pkg.sv | 25 ++
 rtl/svreal_align_sat_mod.sv | 42 ++++
 rtl/svreal_mac_pipe_mod.sv | 155 +++++++++++++++
 tb/tb_svreal_mac_pipe_mod.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/svreal_pkg.sv
// Shared constants and signed saturation helpers for the svreal datapath blocks.
package svreal_pkg;
  localparam int SVREAL_EXP_W = 16;

  localparam logic SVREAL_MAC_MODE_ACC = 1'b0;
  localparam logic SVREAL_MAC_MODE_MUL = 1'b1;

  function automatic logic signed [63:0] sat_max(input int w);
    return (64'sd1 <<< (w - 1)) - 64'sd1;
  endfunction

  function automatic logic signed [63:0] sat_min(input int w);
    return -(64'sd1 <<< (w - 1));
  endfunction

  function automatic logic sat_hit(input logic signed [63:0] x, input int w);
    return (x > sat_max(w)) || (x < sat_min(w));
  endfunction

  function automatic logic signed [63:0] sat_clamp(input logic signed [63:0] x, input int w);
    if (x > sat_max(w)) return sat_max(w);
    if (x < sat_min(w)) return sat_min(w);
    return x;
  endfunction
endpackage

// File: rtl/svreal_align_sat_mod.sv
// Re-expresses a wide signed significand at a destination exponent, clamping
// to OUT_W bits and flagging saturation.
module svreal_align_sat_mod import svreal_pkg::*; #(
  parameter int IN_W      = 32,
  parameter int OUT_W     = 24,
  parameter int SRC_EXP_W = 17,
  parameter int DST_EXP_W = 16
) (
  input  logic signed [IN_W-1:0]      in_sig,
  input  logic signed [SRC_EXP_W-1:0] src_exp,
  input  logic signed [DST_EXP_W-1:0] dst_exp,
  output logic signed [OUT_W-1:0]     out_sig,
  output logic                        sat
);
  localparam int SH_W  = SRC_EXP_W + 2;
  localparam int EXT_W = IN_W + OUT_W + 1;
  // Beyond these shift amounts the result is already fully saturated / sign-only.
  localparam logic signed [SH_W-1:0] MAX_L = SH_W'(OUT_W);
  localparam logic signed [SH_W-1:0] MAX_R = SH_W'(IN_W);

  logic signed [SH_W-1:0]  shift, neg_shift;
  logic        [SH_W-1:0]  amt;
  logic signed [EXT_W-1:0] ext;
  logic signed [63:0]      wide, clamped;

  always_comb begin
    shift     = SH_W'(src_exp) - SH_W'(dst_exp);
    neg_shift = -shift;
    ext       = EXT_W'(in_sig);
    if (!shift[SH_W-1]) begin
      amt = (shift > MAX_L) ? MAX_L : shift;
      ext = ext <<< amt;
    end else begin
      amt = (neg_shift > MAX_R) ? MAX_R : neg_shift;
      ext = ext >>> amt;
    end
    wide    = 64'(ext);
    clamped = sat_clamp(wide, OUT_W);
    sat     = sat_hit(wide, OUT_W);
    out_sig = clamped[OUT_W-1:0];
  end
endmodule

// File: rtl/svreal_mac_pipe_mod.sv
// Three-stage svreal multiply-accumulate: operand register, exact multiply +
// align/saturate, then accumulate-or-pass into a held output register.
module svreal_mac_pipe_mod import svreal_pkg::*; #(
  parameter int a_significand_width = 16,
  parameter int b_significand_width = 16,
  parameter int c_significand_width = 24
) (
  input  logic                                  clk,
  input  logic                                  rst_n,
  input  logic                                  cke,
  input  logic signed [a_significand_width-1:0] a_significand,
  input  logic signed [SVREAL_EXP_W-1:0]        a_exponent,
  input  logic signed [b_significand_width-1:0] b_significand,
  input  logic signed [SVREAL_EXP_W-1:0]        b_exponent,
  input  logic signed [SVREAL_EXP_W-1:0]        c_exponent,
  input  logic                                  in_mode,
  input  logic                                  in_last,
  input  logic                                  in_valid,
  output logic                                  in_ready,
  output logic signed [c_significand_width-1:0] c_significand,
  output logic                                  out_sat,
  output logic                                  out_valid,
  input  logic                                  out_ready
);
  localparam int AW   = a_significand_width;
  localparam int BW   = b_significand_width;
  localparam int CW   = c_significand_width;
  localparam int PW   = AW + BW;
  localparam int PE_W = SVREAL_EXP_W + 1;

  logic                  stall;
  logic [2:1]            vld_pipe_q, vld_pipe_d;
  logic signed [AW-1:0]  s1_a_q, s1_a_d;
  logic signed [BW-1:0]  s1_b_q, s1_b_d;
  logic                  s1_mode_q, s1_mode_d, s1_last_q, s1_last_d;
  logic signed [CW-1:0]  s2_sig_q, s2_sig_d;
  logic                  s2_sat_q, s2_sat_d, s2_mode_q, s2_mode_d, s2_last_q, s2_last_d;
  logic signed [CW-1:0]  acc_q, acc_d, c_q, c_d;
  logic                  sticky_q, sticky_d, out_sat_q, out_sat_d, out_valid_q, out_valid_d;

  logic signed [PW-1:0]   prod;
  logic signed [PE_W-1:0] prod_exp;
  logic signed [CW-1:0]   al_sig;
  logic                   al_sat;
  logic signed [CW:0]     sum;
  logic signed [63:0]     sum_w, sum_cl;
  logic                   sat3, sticky_new;

  // All stages advance together, so a held result never lets a bubble collapse.
  assign stall    = !cke || (out_valid_q && !out_ready);
  assign in_ready = rst_n && !stall;

  assign prod     = PW'(s1_a_q) * PW'(s1_b_q);
  assign prod_exp = PE_W'(a_exponent) + PE_W'(b_exponent);

  svreal_align_sat_mod #(
    .IN_W(PW), .OUT_W(CW), .SRC_EXP_W(PE_W), .DST_EXP_W(SVREAL_EXP_W)
  ) u_align (
    .in_sig(prod), .src_exp(prod_exp), .dst_exp(c_exponent),
    .out_sig(al_sig), .sat(al_sat)
  );

  always_comb begin
    vld_pipe_d  = vld_pipe_q;
    s1_a_d      = s1_a_q;
    s1_b_d      = s1_b_q;
    s1_mode_d   = s1_mode_q;
    s1_last_d   = s1_last_q;
    s2_sig_d    = s2_sig_q;
    s2_sat_d    = s2_sat_q;
    s2_mode_d   = s2_mode_q;
    s2_last_d   = s2_last_q;
    acc_d       = acc_q;
    sticky_d    = sticky_q;
    c_d         = c_q;
    out_sat_d   = out_sat_q;
    out_valid_d = out_valid_q;

    sum        = (CW+1)'(s2_sig_q) + (CW+1)'(acc_q);
    sum_w      = 64'(sum);
    sum_cl     = sat_clamp(sum_w, CW);
    sat3       = sat_hit(sum_w, CW);
    sticky_new = sticky_q | s2_sat_q | sat3;

    if (!stall) begin
      vld_pipe_d = {vld_pipe_q[1], in_valid};
      if (in_valid) begin
        s1_a_d    = a_significand;
        s1_b_d    = b_significand;
        s1_mode_d = in_mode;
        s1_last_d = in_last;
      end
      s2_sig_d  = al_sig;
      s2_sat_d  = al_sat;
      s2_mode_d = s1_mode_q;
      s2_last_d = s1_last_q;
      // Not stalled means any held result is being taken this edge.
      out_valid_d = 1'b0;
      if (vld_pipe_q[2]) begin
        if (s2_mode_q == SVREAL_MAC_MODE_MUL) begin
          c_d         = s2_sig_q;
          out_sat_d   = s2_sat_q;
          out_valid_d = 1'b1;
        end else if (s2_last_q) begin
          c_d         = sum_cl[CW-1:0];
          out_sat_d   = sticky_new;
          out_valid_d = 1'b1;
          acc_d       = '0;
          sticky_d    = 1'b0;
        end else begin
          acc_d    = sum_cl[CW-1:0];
          sticky_d = sticky_new;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_pipe_q  <= '0;
      s1_a_q      <= '0;
      s1_b_q      <= '0;
      s1_mode_q   <= 1'b0;
      s1_last_q   <= 1'b0;
      s2_sig_q    <= '0;
      s2_sat_q    <= 1'b0;
      s2_mode_q   <= 1'b0;
      s2_last_q   <= 1'b0;
      acc_q       <= '0;
      sticky_q    <= 1'b0;
      c_q         <= '0;
      out_sat_q   <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      vld_pipe_q  <= vld_pipe_d;
      s1_a_q      <= s1_a_d;
      s1_b_q      <= s1_b_d;
      s1_mode_q   <= s1_mode_d;
      s1_last_q   <= s1_last_d;
      s2_sig_q    <= s2_sig_d;
      s2_sat_q    <= s2_sat_d;
      s2_mode_q   <= s2_mode_d;
      s2_last_q   <= s2_last_d;
      acc_q       <= acc_d;
      sticky_q    <= sticky_d;
      c_q         <= c_d;
      out_sat_q   <= out_sat_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign c_significand = c_q;
  assign out_sat       = out_sat_q;
  assign out_valid     = out_valid_q;
endmodule

// File: tb/tb_svreal_mac_pipe_mod.sv
// Directed + randomized bench for svreal_mac_pipe_mod against an arithmetic
// reference model of the multiply/align/accumulate rules.
module tb_svreal_mac_pipe_mod;
  localparam int CW = 24;
  localparam longint CMAX = (longint'(1) <<< (CW - 1)) - 1;
  localparam longint CMIN = -(longint'(1) <<< (CW - 1));

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic cke = 1'b1;
  logic signed [15:0] a_sig, b_sig, a_exp, b_exp, c_exp;
  logic in_mode, in_last, in_valid, in_ready, out_sat, out_valid, out_ready;
  logic signed [CW-1:0] c_sig;

  svreal_mac_pipe_mod #(.a_significand_width(16), .b_significand_width(16),
                        .c_significand_width(CW)) dut (
    .clk(clk), .rst_n(rst_n), .cke(cke),
    .a_significand(a_sig), .a_exponent(a_exp),
    .b_significand(b_sig), .b_exponent(b_exp), .c_exponent(c_exp),
    .in_mode(in_mode), .in_last(in_last), .in_valid(in_valid), .in_ready(in_ready),
    .c_significand(c_sig), .out_sat(out_sat), .out_valid(out_valid), .out_ready(out_ready)
  );

  always #5 clk = ~clk;

  typedef struct { longint c; bit s; int done; } res_t;
  res_t   exp_q[$];
  longint got_c[$];
  bit     got_s[$];
  longint m_acc = 0;
  bit     m_sticky = 1'b0;
  int total = 0, bad = 0, cyc = 0, chk_lat = 3, bp_from = -1, bp_to = -1;
  bit rnd_ordy = 1'b0, seen = 1'b0;

  task automatic chk(input string tag, input longint obs, input longint expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  function automatic longint clampc(input longint x, output bit s);
    s = (x > CMAX) || (x < CMIN);
    return (x > CMAX) ? CMAX : ((x < CMIN) ? CMIN : x);
  endfunction

  // Value of p * 2^(ea+eb) expressed in units of 2^ec, floored, then clamped.
  function automatic longint align(input longint p, output bit s);
    int sh;
    longint v, d;
    sh = int'(a_exp) + int'(b_exp) - int'(c_exp);
    if (sh >= 0) v = p * (longint'(1) << sh);
    else begin
      d = longint'(1) << (-sh);
      v = p / d;
      if ((p % d) != 0 && p < 0) v = v - 1;
    end
    return clampc(v, s);
  endfunction

  task automatic model_beat(input int a, input int b, input bit m, input bit l);
    bit s2, s3;
    longint al, sum;
    res_t r;
    al = align(longint'(a) * longint'(b), s2);
    r.done = cyc;
    if (m) begin
      r.c = al; r.s = s2; exp_q.push_back(r);
    end else begin
      sum = clampc(m_acc + al, s3);
      if (l) begin
        r.c = sum; r.s = m_sticky | s2 | s3; exp_q.push_back(r);
        m_acc = 0; m_sticky = 1'b0;
      end else begin
        m_acc = sum; m_sticky = m_sticky | s2 | s3;
      end
    end
  endtask

  task automatic step(input bit v, input int a, input int b, input bit m, input bit l,
                      output bit took);
    bit ixfer, oxfer;
    in_valid = v; a_sig = a[15:0]; b_sig = b[15:0]; in_mode = m; in_last = l;
    out_ready = rnd_ordy ? ($urandom_range(0, 3) != 0) : !(cyc >= bp_from && cyc < bp_to);
    #3;
    ixfer = in_valid && in_ready;
    oxfer = out_valid && out_ready && cke;
    chk("in_ready", in_ready, cke && !(out_valid && !out_ready));
    if (out_valid) begin
      if (exp_q.size() == 0) chk("spurious_valid", out_valid, 0);
      else begin
        chk("c_sig", c_sig, exp_q[0].c);
        chk("out_sat", out_sat, exp_q[0].s);
        if (!seen && chk_lat != 0) chk("latency", cyc - exp_q[0].done, chk_lat);
        seen = 1'b1;
        if (oxfer) begin
          got_c.push_back(c_sig); got_s.push_back(out_sat);
          void'(exp_q.pop_front()); seen = 1'b0;
        end
      end
    end
    if (ixfer) model_beat(int'(a_sig), int'(b_sig), m, l);
    took = ixfer;
    @(posedge clk); #1;
    cyc++;
  endtask

  task automatic send(input int a, input int b, input bit m, input bit l);
    bit t;
    int n;
    n = 0;
    do begin step(1'b1, a, b, m, l, t); n++; end while (!t && n < 50);
    if (!t) chk("send_accept", t, 1);
  endtask

  task automatic idle(input int n);
    bit t;
    repeat (n) step(1'b0, 0, 0, 1'b0, 1'b0, t);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 60) begin idle(1); n++; end
    chk("drain_left", exp_q.size(), 0);
  endtask

  task automatic clr();
    got_c.delete(); got_s.delete();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    a_exp = -16'sd8; b_exp = -16'sd8; c_exp = -16'sd12;
    in_valid = 1'b0; in_mode = 1'b0; in_last = 1'b0; a_sig = '0; b_sig = '0; out_ready = 1'b1;
    #3;
    chk("rst_valid", out_valid, 0);
    chk("rst_c", c_sig, 0);
    chk("rst_sat", out_sat, 0);
    chk("rst_ready", in_ready, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // 4-beat accumulate: 4 * 3.0 = 12.0
    clr();
    repeat (3) send(384, 512, 1'b0, 1'b0);
    send(384, 512, 1'b0, 1'b1);
    drain();
    chk("acc_cnt", got_c.size(), 1);
    chk("acc_val", got_c[0], 49152);
    chk("acc_sat", got_s[0], 0);

    // saturation both ways, then a clean packet clears the flag
    clr();
    send(32512, 32512, 1'b0, 1'b1);
    send(-32512, 32512, 1'b0, 1'b1);
    send(384, 512, 1'b0, 1'b1);
    drain();
    chk("sat_cnt", got_c.size(), 3);
    chk("sat_pos", got_c[0], 8388607);
    chk("sat_pos_f", got_s[0], 1);
    chk("sat_neg", got_c[1], -8388608);
    chk("sat_neg_f", got_s[1], 1);
    chk("clean_val", got_c[2], 12288);
    chk("clean_f", got_s[2], 0);

    // MUL beat inside an ACC packet
    clr();
    send(384, 512, 1'b0, 1'b0);
    send(256, 256, 1'b1, 1'b0);
    send(384, 512, 1'b0, 1'b1);
    drain();
    chk("mix_cnt", got_c.size(), 2);
    chk("mix_mul", got_c[0], 4096);
    chk("mix_acc", got_c[1], 24576);

    // backpressure window while beats keep arriving
    clr();
    chk_lat = 0; bp_from = cyc + 4; bp_to = bp_from + 5;
    for (int i = 0; i < 6; i++) send(100 + i * 10, 512, 1'b0, i[0]);
    drain();
    bp_from = -1; bp_to = -1; chk_lat = 3;
    chk("bp_cnt", got_c.size(), 3);
    chk("bp_0", got_c[0], 6720);
    chk("bp_1", got_c[1], 8000);
    chk("bp_2", got_c[2], 9280);

    // reset mid-packet with a held result
    bp_from = cyc; bp_to = cyc + 100;
    send(384, 512, 1'b0, 1'b0);
    send(384, 512, 1'b0, 1'b0);
    send(256, 256, 1'b1, 1'b0);
    idle(3);
    chk("pre_rst_valid", out_valid, 1);
    #1 rst_n = 1'b0;
    #1;
    chk("async_rst_valid", out_valid, 0);
    chk("async_rst_ready", in_ready, 0);
    chk("async_rst_c", c_sig, 0);
    exp_q.delete(); m_acc = 0; m_sticky = 1'b0; seen = 1'b0; bp_from = -1; bp_to = -1;
    @(posedge clk); #1;
    rst_n = 1'b1; cyc++;
    clr();
    send(384, 512, 1'b0, 1'b1);
    drain();
    chk("post_rst_cnt", got_c.size(), 1);
    chk("post_rst_val", got_c[0], 12288);

    // clock-enable freeze right after the last beat delays output by 3
    clr();
    send(384, 512, 1'b0, 1'b0);
    send(384, 512, 1'b0, 1'b1);
    chk_lat = 6; cke = 1'b0;
    idle(3);
    cke = 1'b1;
    drain();
    chk_lat = 3;
    chk("cke_cnt", got_c.size(), 1);
    chk("cke_val", got_c[0], 24576);

    // left-shift alignment (c_exponent below product exponent)
    c_exp = -16'sd20;
    clr();
    send(3, 5, 1'b1, 1'b0);
    send(-7, 9, 1'b0, 1'b1);
    send(32767, 32767, 1'b1, 1'b0);
    drain();
    chk("lsh_mul", got_c[0], 240);
    chk("lsh_acc", got_c[1], -1008);
    chk("lsh_sat", got_s[2], 1);
    c_exp = -16'sd12;

    // randomized traffic
    rnd_ordy = 1'b1; chk_lat = 0;
    repeat (300) begin
      logic [15:0] r;
      int a, b;
      bit t;
      r = 16'($urandom);
      a = ($urandom_range(0, 1) != 0) ? int'($signed(r)) : int'($urandom_range(0, 1200)) - 600;
      r = 16'($urandom);
      b = ($urandom_range(0, 1) != 0) ? int'($signed(r)) : int'($urandom_range(0, 1200)) - 600;
      step($urandom_range(0, 3) != 0, a, b, $urandom_range(0, 3) == 0,
           $urandom_range(0, 2) == 0, t);
    end
    rnd_ordy = 1'b0;
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
